// File: rtl/spi_sd_pkg.sv
// spi_sd_pkg
// Constants and types shared by the SD-card SPI command sender and response
// reader that sit on the same SPI byte engine.
//
// Contents:
//   SD_FILL_BYTE            byte clocked out while only receiving (0xFF)
//   SD_RESP_MAX_BYTES       largest trailing payload after R1 (R3/R7 = 4)
//   SD_R1_START_BIT         bit that is 0 in the first byte of a response
//   SD_POLL_LIMIT_DEFAULT   default NCR filler-byte budget
//   SD_BUSY_LIMIT_DEFAULT   default R1b busy-byte budget
//   resp_state_e            response reader state encoding
//   clamp_resp_len()        limits a requested trailing length to 4

package spi_sd_pkg;

  localparam logic [7:0] SD_FILL_BYTE          = 8'hFF;
  localparam int         SD_RESP_MAX_BYTES     = 4;
  localparam int         SD_R1_START_BIT       = 7;
  localparam int         SD_POLL_LIMIT_DEFAULT = 8;
  localparam int         SD_BUSY_LIMIT_DEFAULT = 65535;

  typedef enum logic [2:0] {
    RESP_IDLE      = 3'd0,
    RESP_POLL_SEND = 3'd1,
    RESP_POLL_WAIT = 3'd2,
    RESP_DATA_SEND = 3'd3,
    RESP_DATA_WAIT = 3'd4,
    RESP_BUSY_SEND = 3'd5,
    RESP_BUSY_WAIT = 3'd6,
    RESP_DONE      = 3'd7
  } resp_state_e;

  function automatic logic [2:0] clamp_resp_len(input logic [2:0] len);
    return (len > 3'(SD_RESP_MAX_BYTES)) ? 3'(SD_RESP_MAX_BYTES) : len;
  endfunction

endpackage

// File: rtl/spi_response_reader.sv
// spi_response_reader
// Receive side of the SD-card SPI command path. After the command sender has
// shifted out a frame, this block clocks 0xFF filler bytes through the shared
// byte engine, hunts for the R1 start byte (first byte with bit 7 clear),
// collects 0-4 trailing bytes (R3/R7) and optionally polls out the R1b busy
// phase (busy while the card returns 0x00).
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   resp_start    one-cycle request, honoured only while idle
//   resp_len      trailing bytes after R1, values above 4 clamp to 4
//   resp_busy     1 = R1b response, poll busy after the trailing bytes
//   resp_rdy      one-cycle completion pulse
//   resp_timeout  R1 hunt or busy poll ran out of budget; held until the
//                 next accepted request
//   resp_r1       captured R1 byte, 0xFF after a poll timeout
//   resp_data     trailing bytes, MSB-first, right-aligned
//   start         one-cycle byte-transfer request to the byte engine
//   data          transmit byte, always the fill byte
//   rdy           byte engine done, rx_data valid this cycle
//   rx_data       byte received during the last transfer

module spi_response_reader
  import spi_sd_pkg::*;
#(
  parameter int POLL_LIMIT = SD_POLL_LIMIT_DEFAULT,  // 1..255
  parameter int BUSY_LIMIT = SD_BUSY_LIMIT_DEFAULT   // 1..65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resp_start,
  input  logic [2:0]  resp_len,
  input  logic        resp_busy,
  output logic        resp_rdy,
  output logic        resp_timeout,
  output logic [7:0]  resp_r1,
  output logic [31:0] resp_data,
  output logic        start,
  output logic [7:0]  data,
  input  logic        rdy,
  input  logic [7:0]  rx_data
);

  localparam logic [7:0]  POLL_LIMIT_C = 8'(POLL_LIMIT);
  localparam logic [15:0] BUSY_LIMIT_C = 16'(BUSY_LIMIT);

  resp_state_e state;
  logic [2:0]  len_q;
  logic        busy_q;
  logic [7:0]  poll_cnt;
  logic [15:0] busy_cnt;

  logic [7:0]  poll_cnt_inc;
  logic [15:0] busy_cnt_inc;
  resp_state_e after_resp;

  assign data         = SD_FILL_BYTE;
  assign poll_cnt_inc = poll_cnt + 8'd1;
  assign busy_cnt_inc = busy_cnt + 16'd1;
  // Where to go once R1 and any trailing bytes are in.
  assign after_resp   = busy_q ? RESP_BUSY_SEND : RESP_DONE;

  // start and resp_rdy are registered and set on the transition into the
  // SEND/DONE states, so each is high for exactly the one cycle spent there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RESP_IDLE;
      len_q        <= '0;
      busy_q       <= 1'b0;
      poll_cnt     <= '0;
      busy_cnt     <= '0;
      start        <= 1'b0;
      resp_rdy     <= 1'b0;
      resp_timeout <= 1'b0;
      resp_r1      <= SD_FILL_BYTE;
      resp_data    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every branch below sees
      // the register values from the start of the cycle; the pulse outputs
      // default low here and are raised only by the transitions that need them.
      start    <= 1'b0;
      resp_rdy <= 1'b0;

      case (state)
        RESP_IDLE: begin
          if (resp_start) begin
            len_q        <= clamp_resp_len(resp_len);
            busy_q       <= resp_busy;
            resp_timeout <= 1'b0;
            resp_data    <= '0;
            poll_cnt     <= '0;
            busy_cnt     <= '0;
            start        <= 1'b1;
            state        <= RESP_POLL_SEND;
          end
        end

        RESP_POLL_SEND: state <= RESP_POLL_WAIT;

        RESP_POLL_WAIT: begin
          if (rdy) begin
            if (!rx_data[SD_R1_START_BIT]) begin
              resp_r1 <= rx_data;
              if (len_q != 3'd0) begin
                start <= 1'b1;
                state <= RESP_DATA_SEND;
              end else begin
                start    <= busy_q;
                resp_rdy <= ~busy_q;
                state    <= after_resp;
              end
            end else begin
              poll_cnt <= poll_cnt_inc;
              if (poll_cnt_inc == POLL_LIMIT_C) begin
                // No response at all: the busy phase is meaningless, skip it.
                resp_r1      <= SD_FILL_BYTE;
                resp_timeout <= 1'b1;
                resp_rdy     <= 1'b1;
                state        <= RESP_DONE;
              end else begin
                start <= 1'b1;
                state <= RESP_POLL_SEND;
              end
            end
          end
        end

        RESP_DATA_SEND: state <= RESP_DATA_WAIT;

        RESP_DATA_WAIT: begin
          if (rdy) begin
            // Trailing bytes carry arbitrary data, so no start-bit check here.
            resp_data <= {resp_data[23:0], rx_data};
            len_q     <= len_q - 3'd1;
            if (len_q == 3'd1) begin
              start    <= busy_q;
              resp_rdy <= ~busy_q;
              state    <= after_resp;
            end else begin
              start <= 1'b1;
              state <= RESP_DATA_SEND;
            end
          end
        end

        RESP_BUSY_SEND: state <= RESP_BUSY_WAIT;

        RESP_BUSY_WAIT: begin
          if (rdy) begin
            if (rx_data == 8'h00) begin
              busy_cnt <= busy_cnt_inc;
              if (busy_cnt_inc == BUSY_LIMIT_C) begin
                resp_timeout <= 1'b1;
                resp_rdy     <= 1'b1;
                state        <= RESP_DONE;
              end else begin
                start <= 1'b1;
                state <= RESP_BUSY_SEND;
              end
            end else begin
              resp_rdy <= 1'b1;
              state    <= RESP_DONE;
            end
          end
        end

        RESP_DONE: state <= RESP_IDLE;

        default: state <= RESP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_response_reader.sv
// tb_spi_response_reader
// Two readers share the bench: instance 0 uses the default limits
// (POLL_LIMIT=8, BUSY_LIMIT=65535), instance 1 uses POLL_LIMIT=1,
// BUSY_LIMIT=2. Each has a byte-engine model that answers every start pulse
// after a random delay with the next byte of a per-instance stream, and may
// raise stray rdy pulses while no transfer is pending.

module tb_spi_response_reader;

  typedef struct packed {
    logic        got;
    logic        timing;
    logic [7:0]  pulses;
    logic        to;
    logic [7:0]  r1;
    logic [31:0] data;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]       resp_start;
  logic [1:0][2:0]  resp_len;
  logic [1:0]       resp_busy;
  logic [1:0]       resp_rdy;
  logic [1:0]       resp_timeout;
  logic [1:0][7:0]  resp_r1;
  logic [1:0][31:0] resp_data;
  logic [1:0]       start;
  logic [1:0][7:0]  tx_byte;
  logic [1:0]       rdy;
  logic [1:0][7:0]  rx_data;

  logic [1:0]  rdy_real;
  logic [1:0]  pend;
  int          dly [2];
  logic [7:0]  eptr [2];
  logic [7:0]  wp [2];
  logic [7:0]  mem [2][256];
  bit          stray_en = 1'b0;

  int cyc = 0;
  int pulses [2] = '{0, 0};
  int last_rdy [2] = '{0, 0};
  int rr_cnt [2] = '{0, 0};
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_response_reader #(
      .POLL_LIMIT((g == 0) ? 8 : 1),
      .BUSY_LIMIT((g == 0) ? 65535 : 2)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .resp_start  (resp_start[g]),
      .resp_len    (resp_len[g]),
      .resp_busy   (resp_busy[g]),
      .resp_rdy    (resp_rdy[g]),
      .resp_timeout(resp_timeout[g]),
      .resp_r1     (resp_r1[g]),
      .resp_data   (resp_data[g]),
      .start       (start[g]),
      .data        (tx_byte[g]),
      .rdy         (rdy[g]),
      .rx_data     (rx_data[g])
    );
  end

  // Byte-engine models.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy      <= '0;
      rdy_real <= '0;
      pend     <= '0;
      rx_data  <= '0;
      for (int i = 0; i < 2; i++) begin
        dly[i]  <= 0;
        eptr[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        rdy[i]      <= 1'b0;
        rdy_real[i] <= 1'b0;
        rx_data[i]  <= 8'($urandom);
        if (pend[i]) begin
          if (dly[i] == 0) begin
            rdy[i]      <= 1'b1;
            rdy_real[i] <= 1'b1;
            rx_data[i]  <= mem[i][eptr[i]];
            eptr[i]     <= eptr[i] + 8'd1;
            pend[i]     <= 1'b0;
          end else begin
            dly[i] <= dly[i] - 1;
          end
        end else if (start[i]) begin
          pend[i] <= 1'b1;
          dly[i]  <= int'($urandom_range(0, 3));
        end else if (stray_en && $urandom_range(0, 3) == 0) begin
          rdy[i] <= 1'b1;
        end
      end
    end
  end

  // Event monitor: start pulses, last genuine rdy, completion pulses.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (start[i])    pulses[i]   <= pulses[i] + 1;
      if (rdy_real[i]) last_rdy[i] <= cyc;
      if (resp_rdy[i]) rr_cnt[i]   <= rr_cnt[i] + 1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic string fmt(input res_t r);
    return $sformatf("rdy=%0b timing=%0b pulses=%0d timeout=%0b r1=%h data=%h",
                     r.got, r.timing, r.pulses, r.to, r.r1, r.data);
  endfunction

  function automatic res_t mk(input int p, input bit to, input logic [7:0] r1,
                              input logic [31:0] d);
    res_t r;
    r.got = 1'b1; r.timing = 1'b1; r.pulses = 8'(p); r.to = to; r.r1 = r1; r.data = d;
    return r;
  endfunction

  // Reference model: walk the byte stream the way an SD host reads a response.
  function automatic res_t model(input int g, input int len_in, input bit busy,
                                 input logic [7:0] base);
    res_t r;
    int plim, blim, len, idx;
    bit found, stop;
    logic [7:0] x;
    plim  = (g == 0) ? 8 : 1;
    blim  = (g == 0) ? 65535 : 2;
    len   = (len_in > 4) ? 4 : len_in;
    idx   = 0;
    found = 1'b0;
    stop  = 1'b0;
    r = mk(0, 1'b0, 8'hFF, 32'h0);
    for (int p = 0; p < plim && !found; p++) begin
      x = mem[g][8'(int'(base) + idx)];
      idx++;
      if (x < 8'h80) begin
        found = 1'b1;
        r.r1  = x;
      end
    end
    if (!found) r.to = 1'b1;
    else begin
      for (int i = 0; i < len; i++) begin
        x = mem[g][8'(int'(base) + idx)];
        idx++;
        r.data = {r.data[23:0], x};
      end
      if (busy) begin
        for (int b = 0; b < blim && !stop; b++) begin
          x = mem[g][8'(int'(base) + idx)];
          idx++;
          if (x != 8'h00) stop = 1'b1;
          else if (b == blim - 1) r.to = 1'b1;
        end
      end
    end
    r.pulses = 8'(idx);
    return r;
  endfunction

  task automatic load_begin(input int g);
    wp[g] = eptr[g];
  endtask

  task automatic put(input int g, input logic [7:0] b);
    mem[g][wp[g]] = b;
    wp[g] = wp[g] + 8'd1;
  endtask

  task automatic load_end(input int g);
    for (int i = 0; i < 64; i++) put(g, 8'hFF);
  endtask

  // Issues one request and collects the outcome. quick=1 returns in the
  // completion cycle so the caller can act in the cycles right after it.
  task automatic run_txn(input int g, input int len, input bit busy,
                         input int poke, input bit quick, output res_t r);
    int base;
    bit ok;
    r  = '0;
    ok = 1'b1;
    @(negedge clk);
    base = pulses[g];
    resp_start[g] = 1'b1;
    resp_len[g]   = 3'(len);
    resp_busy[g]  = busy;
    @(negedge clk);
    resp_start[g] = 1'b0;
    resp_len[g]   = 3'($urandom);
    resp_busy[g]  = 1'($urandom);
    if (start[g] !== 1'b1) ok = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (resp_rdy[g] === 1'b1) break;
      resp_start[g] = (k == poke);
      @(negedge clk);
    end
    resp_start[g] = 1'b0;
    r.got  = resp_rdy[g];
    r.r1   = resp_r1[g];
    r.data = resp_data[g];
    r.to   = resp_timeout[g];
    if (cyc != last_rdy[g] + 1) ok = 1'b0;
    if (!quick) begin
      repeat (3) begin
        @(negedge clk);
        if (resp_rdy[g] !== 1'b0) ok = 1'b0;
      end
      if (resp_r1[g] !== r.r1 || resp_data[g] !== r.data || resp_timeout[g] !== r.to)
        ok = 1'b0;
    end
    r.pulses = 8'(pulses[g] - base);
    r.timing = ok;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if (start[i] !== 1'b0) $display("FAIL reset_start[%0d]: got %b, expected 0", i, start[i]);
      else n_pass++;
      n_total++;
      if (resp_rdy[i] !== 1'b0) $display("FAIL reset_resp_rdy[%0d]: got %b, expected 0", i, resp_rdy[i]);
      else n_pass++;
      n_total++;
      if (resp_timeout[i] !== 1'b0) $display("FAIL reset_timeout[%0d]: got %b, expected 0", i, resp_timeout[i]);
      else n_pass++;
      n_total++;
      if (resp_r1[i] !== 8'hFF) $display("FAIL reset_r1[%0d]: got %h, expected ff", i, resp_r1[i]);
      else n_pass++;
      n_total++;
      if (resp_data[i] !== 32'h0) $display("FAIL reset_data[%0d]: got %h, expected 0", i, resp_data[i]);
      else n_pass++;
      n_total++;
      if (tx_byte[i] !== 8'hFF) $display("FAIL reset_tx_byte[%0d]: got %h, expected ff", i, tx_byte[i]);
      else n_pass++;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (start !== 2'b00) $display("FAIL idle_no_start: got %b, expected 00", start);
    else n_pass++;
  endtask

  task automatic test_r1_ncr();
    res_t r, exp;
    load_begin(0); put(0, 8'hFF); put(0, 8'hFF); put(0, 8'h01); load_end(0);
    exp = mk(3, 1'b0, 8'h01, 32'h0);
    run_txn(0, 0, 1'b0, -1, 1'b0, r);
    n_total++;
    if (r !== exp) $display("FAIL r1_ncr: %s, expected %s", fmt(r), fmt(exp));
    else n_pass++;
  endtask

  task automatic test_r7();
    res_t r, exp;
    load_begin(0);
    put(0, 8'hFF); put(0, 8'h01); put(0, 8'h00); put(0, 8'h00); put(0, 8'h01); put(0, 8'hAA);
    load_end(0);
    exp = mk(6, 1'b0, 8'h01, 32'h000001AA);
    run_txn(0, 4, 1'b0, -1, 1'b0, r);
    n_total++;
    if (r !== exp) $display("FAIL r7: %s, expected %s", fmt(r), fmt(exp));
    else n_pass++;
  endtask

  task automatic test_poll_timeout();
    res_t r, exp;
    load_begin(0); load_end(0);
    exp = mk(8, 1'b1, 8'hFF, 32'h0);
    run_txn(0, 2, 1'b1, -1, 1'b0, r);
    n_total++;
    if (r !== exp) $display("FAIL poll_timeout: %s, expected %s", fmt(r), fmt(exp));
    else n_pass++;
  endtask

  task automatic test_r1b();
    res_t r, exp;
    load_begin(0);
    put(0, 8'h00); put(0, 8'h00); put(0, 8'h00); put(0, 8'h00); put(0, 8'hFF);
    load_end(0);
    exp = mk(5, 1'b0, 8'h00, 32'h0);
    run_txn(0, 0, 1'b1, -1, 1'b0, r);
    n_total++;
    if (r !== exp) $display("FAIL r1b: %s, expected %s", fmt(r), fmt(exp));
    else n_pass++;
  endtask

  task automatic test_busy_timeout();
    res_t r, exp;
    load_begin(1);
    put(1, 8'h00); put(1, 8'h00); put(1, 8'h00); put(1, 8'h00); put(1, 8'h00);
    load_end(1);
    exp = mk(3, 1'b1, 8'h00, 32'h0);
    run_txn(1, 0, 1'b1, -1, 1'b0, r);
    n_total++;
    if (r !== exp) $display("FAIL busy_timeout: %s, expected %s", fmt(r), fmt(exp));
    else n_pass++;
  endtask

  task automatic test_poll_limit_one();
    res_t r, exp;
    load_begin(1); put(1, 8'hFF); put(1, 8'h05); load_end(1);
    exp = mk(1, 1'b1, 8'hFF, 32'h0);
    run_txn(1, 0, 1'b0, -1, 1'b0, r);
    n_total++;
    if (r !== exp) $display("FAIL poll_limit_one_timeout: %s, expected %s", fmt(r), fmt(exp));
    else n_pass++;
    load_begin(1); put(1, 8'h05); load_end(1);
    exp = mk(1, 1'b0, 8'h05, 32'h0);
    run_txn(1, 0, 1'b0, -1, 1'b0, r);
    n_total++;
    if (r !== exp) $display("FAIL poll_limit_one_hit: %s, expected %s", fmt(r), fmt(exp));
    else n_pass++;
  endtask

  task automatic test_clamp_ignore();
    res_t r, exp;
    load_begin(0);
    put(0, 8'h01); put(0, 8'h11); put(0, 8'h22); put(0, 8'h33);
    put(0, 8'h44); put(0, 8'h55); put(0, 8'h66);
    load_end(0);
    exp = mk(5, 1'b0, 8'h01, 32'h11223344);
    run_txn(0, 7, 1'b0, 3, 1'b0, r);
    n_total++;
    if (r !== exp) $display("FAIL clamp_ignore: %s, expected %s", fmt(r), fmt(exp));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    res_t r, exp;
    int base;
    load_begin(0);
    put(0, 8'hFF); put(0, 8'h05); put(0, 8'hFF); put(0, 8'h06); put(0, 8'hFF); put(0, 8'h07);
    load_end(0);
    exp = mk(2, 1'b0, 8'h05, 32'h0);
    run_txn(0, 0, 1'b0, -1, 1'b1, r);
    n_total++;
    if (r !== exp) $display("FAIL b2b_first: %s, expected %s", fmt(r), fmt(exp));
    else n_pass++;
    // Request during the completion cycle must be dropped.
    base = pulses[0];
    resp_start[0] = 1'b1;
    @(negedge clk);
    resp_start[0] = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (pulses[0] !== base) $display("FAIL b2b_done_ignored: pulses %0d, expected %0d", pulses[0], base);
    else n_pass++;
    exp = mk(2, 1'b0, 8'h06, 32'h0);
    run_txn(0, 0, 1'b0, -1, 1'b1, r);
    n_total++;
    if (r !== exp) $display("FAIL b2b_second: %s, expected %s", fmt(r), fmt(exp));
    else n_pass++;
    // Request in the cycle right after resp_rdy must be accepted.
    exp = mk(2, 1'b0, 8'h07, 32'h0);
    run_txn(0, 0, 1'b0, -1, 1'b0, r);
    n_total++;
    if (r !== exp) $display("FAIL b2b_after_rdy: %s, expected %s", fmt(r), fmt(exp));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    res_t r, exp;
    int base, rr0;
    bit hit;
    load_begin(0);
    put(0, 8'hFF); put(0, 8'h01); put(0, 8'h11); put(0, 8'h22); put(0, 8'h33); put(0, 8'h44);
    load_end(0);
    @(negedge clk);
    base = pulses[0];
    resp_start[0] = 1'b1;
    resp_len[0]   = 3'd4;
    resp_busy[0]  = 1'b0;
    @(negedge clk);
    resp_start[0] = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      if (start[0] === 1'b1 && pulses[0] - base >= 2) hit = 1'b1;
      else @(negedge clk);
    end
    n_total++;
    if (!hit) $display("FAIL reset_mid_reach: data phase reached %b, expected 1", hit);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (start[0] !== 1'b0) $display("FAIL reset_mid_start: got %b, expected 0", start[0]);
    else n_pass++;
    n_total++;
    if (resp_r1[0] !== 8'hFF) $display("FAIL reset_mid_r1: got %h, expected ff", resp_r1[0]);
    else n_pass++;
    rr0 = rr_cnt[0];
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    n_total++;
    if (rr_cnt[0] !== rr0) $display("FAIL reset_mid_no_rdy: resp_rdy pulses %0d, expected %0d", rr_cnt[0], rr0);
    else n_pass++;
    load_begin(0); put(0, 8'hFF); put(0, 8'h01); load_end(0);
    exp = mk(2, 1'b0, 8'h01, 32'h0);
    run_txn(0, 0, 1'b0, -1, 1'b0, r);
    n_total++;
    if (r !== exp) $display("FAIL reset_mid_recover: %s, expected %s", fmt(r), fmt(exp));
    else n_pass++;
  endtask

  task automatic test_random();
    res_t r, exp;
    int g, len, n_ff, n_z, poke;
    bit busy;
    for (int t = 0; t < 40; t++) begin
      g    = int'($urandom_range(0, 1));
      len  = int'($urandom_range(0, 7));
      busy = 1'($urandom);
      poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : -1;
      load_begin(g);
      n_ff = int'($urandom_range(0, 9));
      for (int i = 0; i < n_ff; i++) put(g, 8'h80 | 8'($urandom));
      put(g, 8'($urandom) & 8'h7F);
      for (int i = 0; i < 6; i++) put(g, 8'($urandom));
      n_z = int'($urandom_range(0, 3));
      for (int i = 0; i < n_z; i++) put(g, 8'h00);
      put(g, 8'($urandom) | 8'h01);
      load_end(g);
      exp = model(g, len, busy, eptr[g]);
      run_txn(g, len, busy, poke, 1'b0, r);
      n_total++;
      if (r !== exp)
        $display("FAIL random[%0d] inst%0d len=%0d busy=%0b: %s, expected %s",
                 t, g, len, busy, fmt(r), fmt(exp));
      else n_pass++;
    end
  endtask

  initial begin
    resp_start = '0;
    resp_len   = '0;
    resp_busy  = '0;
    wp[0] = 8'd0;
    wp[1] = 8'd0;
    test_reset();
    stray_en = 1'b1;
    test_r1_ncr();
    test_r7();
    test_poll_timeout();
    test_r1b();
    test_busy_timeout();
    test_poll_limit_one();
    test_clamp_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
